// File: rtl/lfsr_rr_sched.sv
// Round-robin arbiter that time-shares one external 26-bit LFSR between NREQ requesters.
// Latency: req seen in IDLE at cycle t -> gnt/rnd_data at t+STEPS+1; back-to-back every STEPS+2.
// Backpressure: none; a requester holds req until its gnt pulse, seed writes wait for next IDLE.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req[NREQ]                per-requester request, held until granted
//   gnt[NREQ], rnd_valid     one-cycle one-hot grant pulse and its qualifier
//   rnd_data[26]             word for the granted requester; holds last word between grants
//   seed_wr, seed[26]        reseed pulse and value; seed_ack pulses when it reaches the LFSR
//   lfsr_rst_n/load/din      drive the shared LFSR; lfsr_q is its current state
// Optional: define LFSR_RR_STAT_EN to add gnt_cnt[16] and seed_cnt[8] statistics outputs.
module lfsr_rr_sched #(
    parameter int          NREQ      = 4,
    parameter int          STEPS     = 4,
    parameter logic [25:0] SEED_INIT = 26'h2AAAAAA
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic            rnd_valid,
    output logic [25:0]     rnd_data,
    input  logic            seed_wr,
    input  logic [25:0]     seed,
    output logic            seed_ack,
    output logic            lfsr_rst_n,
    output logic            lfsr_load,
    output logic [25:0]     lfsr_din,
    input  logic [25:0]     lfsr_q
`ifdef LFSR_RR_STAT_EN
    ,
    output logic [15:0]     gnt_cnt,
    output logic [7:0]      seed_cnt
`endif
);

    localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [3:0] STEPS_M1 = 4'(STEPS - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_SEED  = 3'd2,
        S_ADV   = 3'd3,
        S_GRANT = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_nxt;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   winner_nxt;
    logic [PW-1:0]   pick;
    logic [3:0]      step_cnt;
    logic [3:0]      step_cnt_nxt;
    logic            pend;
    logic [25:0]     seed_q;
    logic [25:0]     rnd_hold;
    logic            load_c;
    logic [25:0]     din_c;
    logic [NREQ-1:0] gnt_c;
    logic            ack_c;

    // First asserted request at or after the pointer, searching cyclically.
    always_comb begin : pick_blk
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        pick  = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            ptr      <= '0;
            winner   <= '0;
            step_cnt <= '0;
            pend     <= 1'b0;
            seed_q   <= '0;
            rnd_hold <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            winner   <= winner_nxt;
            step_cnt <= step_cnt_nxt;
            // A new write always wins, even in the cycle an older seed is applied.
            if (seed_wr) begin
                pend   <= 1'b1;
                seed_q <= seed;
            end else if (state == S_SEED) begin
                pend <= 1'b0;
            end
            if (state == S_GRANT) begin
                rnd_hold <= lfsr_q;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        winner_nxt   = winner;
        step_cnt_nxt = step_cnt;
        load_c       = 1'b1;
        din_c        = lfsr_q;     // reloading q freezes the LFSR
        gnt_c        = '0;
        ack_c        = 1'b0;
        case (state)
            S_INIT: begin
                din_c     = SEED_INIT;
                state_nxt = S_IDLE;
            end
            S_IDLE: begin
                // seed_wr is looked at directly so a same-cycle reseed beats a request.
                if (pend || seed_wr) begin
                    state_nxt = S_SEED;
                end else if (|req) begin
                    winner_nxt   = pick;
                    step_cnt_nxt = '0;
                    state_nxt    = S_ADV;
                end
            end
            S_SEED: begin
                din_c     = seed_q;
                ack_c     = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ADV: begin
                load_c       = 1'b0;
                step_cnt_nxt = step_cnt + 4'd1;
                if (step_cnt == STEPS_M1) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt_c[winner] = 1'b1;
                ptr_nxt       = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT;
            end
        endcase
    end

    assign gnt       = gnt_c;
    assign rnd_valid = |gnt_c;
    assign rnd_data  = (state == S_GRANT) ? lfsr_q : rnd_hold;
    assign seed_ack  = ack_c;

    // The LFSR controls follow rst directly so they read as reset values while rst is high.
    assign lfsr_rst_n = ~rst;
    assign lfsr_load  = ~rst & load_c;
    assign lfsr_din   = rst ? 26'd0 : din_c;

`ifdef LFSR_RR_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt  <= '0;
            seed_cnt <= '0;
        end else begin
            if (state == S_GRANT) begin
                gnt_cnt <= gnt_cnt + 16'd1;
            end
            if (state == S_SEED) begin
                seed_cnt <= seed_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_rr_sched.sv
module tb_lfsr_rr_sched;
    localparam int          NREQ      = 4;
    localparam int          STEPS     = 4;
    localparam logic [25:0] SEED_INIT = 26'h2AAAAAA;
    localparam logic [25:0] TAPS      = 26'h2000023;   // x^26 + x^6 + x^2 + x + 1

    logic            clk     = 1'b0;
    logic            rst     = 1'b1;
    logic [NREQ-1:0] req     = '0;
    logic            seed_wr = 1'b0;
    logic [25:0]     seed    = '0;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [25:0]     rnd_data;
    logic            seed_ack;
    logic            lfsr_rst_n;
    logic            lfsr_load;
    logic [25:0]     lfsr_din;
    logic [25:0]     lfsr_q;
`ifdef LFSR_RR_STAT_EN
    logic [15:0]     gnt_cnt;
    logic [7:0]      seed_cnt;
`endif

    lfsr_rr_sched #(.NREQ(NREQ), .STEPS(STEPS), .SEED_INIT(SEED_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .gnt        (gnt),
        .rnd_valid  (rnd_valid),
        .rnd_data   (rnd_data),
        .seed_wr    (seed_wr),
        .seed       (seed),
        .seed_ack   (seed_ack),
        .lfsr_rst_n (lfsr_rst_n),
        .lfsr_load  (lfsr_load),
        .lfsr_din   (lfsr_din),
        .lfsr_q     (lfsr_q)
`ifdef LFSR_RR_STAT_EN
        ,
        .gnt_cnt    (gnt_cnt),
        .seed_cnt   (seed_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Shared LFSR: Fibonacci shift-left, zero load/state replaced by 1.
    always_ff @(posedge clk or negedge lfsr_rst_n) begin
        if (!lfsr_rst_n)
            lfsr_q <= '0;
        else if (lfsr_load)
            lfsr_q <= (lfsr_din == 26'd0) ? 26'd1 : lfsr_din;
        else
            lfsr_q <= (lfsr_q == 26'd0) ? 26'd1 :
                      {lfsr_q[24:0], lfsr_q[25] ^ lfsr_q[5] ^ lfsr_q[1] ^ lfsr_q[0]};
    end

    // Golden step model: parity of tapped bits shifted in.
    function automatic logic [25:0] adv(input logic [25:0] v, input int n);
        logic [25:0] r;
        r = v;
        for (int i = 0; i < n; i++)
            r = (r == 26'd0) ? 26'd1 : ((r << 1) | 26'(^(r & TAPS)));
        return r;
    endfunction

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit in_rst = 1'b1;
    bit hold_all = 1'b0;

    // Transaction-level model: when the scheduler is next free, and what is owed when.
    int              idle_at = 0, adv_lo = -1, adv_hi = -2, gnt_cyc = -1, ack_cyc = -1, ptr = 0;
    logic [NREQ-1:0] gnt_exp = '0;
    logic [25:0]     word_exp = '0, held = '0, m_q = '0, pend_seed = '0;
    bit              pend = 1'b0;
    int              gcnt_m = 0, scnt_m = 0;

    int              g_cyc[$];
    logic [NREQ-1:0] g_val[$];
    logic [25:0]     g_dat[$];
    int              a_cyc[$];

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        logic [NREQ-1:0] eg;
        if (in_rst) begin
            check("rst_gnt", 26'(gnt), 26'd0);
            check("rst_valid", 26'(rnd_valid), 26'd0);
            check("rst_data", rnd_data, 26'd0);
            check("rst_ack", 26'(seed_ack), 26'd0);
            check("rst_lfsr_rst_n", 26'(lfsr_rst_n), 26'd0);
            check("rst_load", 26'(lfsr_load), 26'd0);
            check("rst_din", lfsr_din, 26'd0);
`ifdef LFSR_RR_STAT_EN
            check("rst_gnt_cnt", 26'(gnt_cnt), 26'd0);
            check("rst_seed_cnt", 26'(seed_cnt), 26'd0);
`endif
        end else begin
            eg = (cyc == gnt_cyc) ? gnt_exp : '0;
            if (cyc == gnt_cyc) held = word_exp;
            check("gnt", 26'(gnt), 26'(eg));
            check("rnd_valid", 26'(rnd_valid), 26'(|eg));
            check("rnd_data", rnd_data, held);
            check("seed_ack", 26'(seed_ack), 26'(cyc == ack_cyc));
            check("lfsr_rst_n", 26'(lfsr_rst_n), 26'd1);
            check("lfsr_load", 26'(lfsr_load), 26'(!(cyc >= adv_lo && cyc <= adv_hi)));
            if (cyc == idle_at) begin
                check("idle_q", lfsr_q, m_q);
                check("idle_din", lfsr_din, m_q);
            end
`ifdef LFSR_RR_STAT_EN
            check("gnt_cnt", 26'(gnt_cnt), 26'(gcnt_m));
            check("seed_cnt", 26'(seed_cnt), 26'(scnt_m));
            if (cyc == gnt_cyc) gcnt_m = (gcnt_m + 1) & 16'hFFFF;
            if (cyc == ack_cyc) scnt_m = (scnt_m + 1) & 8'hFF;
`endif
        end
        if (gnt != '0) begin
            g_cyc.push_back(cyc);
            g_val.push_back(gnt);
            g_dat.push_back(rnd_data);
        end
        if (seed_ack) a_cyc.push_back(cyc);
    endtask

    // Feed this cycle's inputs to the model.
    task automatic commit();
        int w;
        if (rst) begin
            in_rst = 1'b1;
        end else if (in_rst) begin
            in_rst  = 1'b0;
            idle_at = cyc + 1;
            m_q     = SEED_INIT;
            ptr     = 0;
            pend    = 1'b0;
            gnt_cyc = -1;
            ack_cyc = -1;
            adv_lo  = -1;
            adv_hi  = -2;
            held    = '0;
            gcnt_m  = 0;
            scnt_m  = 0;
        end else if (cyc == idle_at) begin
            if (pend || seed_wr) begin
                m_q     = seed_wr ? seed : pend_seed;
                if (m_q == 26'd0) m_q = 26'd1;
                pend    = 1'b0;
                ack_cyc = cyc + 1;
                idle_at = cyc + 2;
            end else if (req != '0) begin
                w = ptr;
                while (!req[w]) w = (w + 1) % NREQ;
                gnt_exp  = NREQ'(1) << w;
                word_exp = adv(m_q, STEPS);
                m_q      = word_exp;
                ptr      = (w + 1) % NREQ;
                adv_lo   = cyc + 1;
                adv_hi   = cyc + STEPS;
                gnt_cyc  = cyc + STEPS + 1;
                idle_at  = cyc + STEPS + 2;
            end else begin
                idle_at = cyc + 1;
            end
        end else if (seed_wr) begin
            pend      = 1'b1;
            pend_seed = seed;
        end
    endtask

    task automatic tick();
        commit();
        @(negedge clk);
        cyc++;
        compare();
        seed_wr = 1'b0;
        if (!hold_all) req = req & ~gnt;
    endtask

    task automatic clear_logs();
        g_cyc.delete();
        g_val.delete();
        g_dat.delete();
        a_cyc.delete();
    endtask

    task automatic wait_grants(input int n, input int budget);
        int k;
        k = 0;
        while (g_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        check("grant_timeout", 26'(g_cyc.size() >= n), 26'd1);
    endtask

    task automatic wait_adv();
        int k;
        k = 0;
        while (lfsr_load !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        check("adv_timeout", 26'(lfsr_load), 26'd0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        #1;
        check("rst_now_gnt", 26'(gnt), 26'd0);
        check("rst_now_load", 26'(lfsr_load), 26'd0);
        check("rst_now_rst_n", 26'(lfsr_rst_n), 26'd0);
        check("rst_now_data", rnd_data, 26'd0);
        repeat (n) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        int t0;
        logic [NREQ-1:0] order [5];
        order[0] = 4'b0010; order[1] = 4'b0100; order[2] = 4'b1000;
        order[3] = 4'b0001; order[4] = 4'b0010;

        // Reset held, then released with no requests.
        repeat (3) tick();
        rst = 1'b0;
        tick();
        repeat (20) tick();
        check("seed_init_hold", lfsr_q, 26'h2AAAAAA);

        // Single requester: latency and first word.
        clear_logs();
        t0  = cyc;
        req = 4'b0001;
        tick();
        wait_grants(1, 20);
        check("b_latency", 26'(g_cyc[0] - t0), 26'd5);
        check("b_gnt", 26'(g_val[0]), 26'b0001);
        check("b_word", g_dat[0], 26'h2AAAAAD);

        // All requesting: rotation from pointer 1 and spacing.
        tick();
        clear_logs();
        hold_all = 1'b1;
        req      = 4'b1111;
        wait_grants(5, 60);
        hold_all = 1'b0;
        req      = '0;
        for (int i = 0; i < 5; i++) check("c_order", 26'(g_val[i]), 26'(order[i]));
        for (int i = 0; i < 4; i++) check("c_spacing", 26'(g_cyc[i+1] - g_cyc[i]), 26'd6);

        // Zero seed written mid-advance: grant first, then seed, then word from state 1.
        tick();
        clear_logs();
        req = 4'b0001;
        wait_adv();
        seed_wr = 1'b1;
        seed    = 26'd0;
        tick();
        k = 0;
        while (a_cyc.size() < 1 && k < 30) begin
            tick();
            k++;
        end
        check("d_order", 26'(g_cyc.size() == 1 && a_cyc.size() == 1 && g_cyc[0] < a_cyc[0]), 26'd1);
        tick();
        check("d_q_one", lfsr_q, 26'd1);
        clear_logs();
        req = 4'b0001;
        wait_grants(1, 20);
        check("d_word", g_dat[0], 26'h000001B);

        // Seed write and request in the same IDLE cycle.
        tick();
        tick();
        clear_logs();
        req     = 4'b0100;
        seed_wr = 1'b1;
        seed    = 26'($urandom);
        tick();
        wait_grants(1, 30);
        check("e_ack_seen", 26'(a_cyc.size()), 26'd1);
        check("e_gap", 26'(g_cyc[0] - a_cyc[0]), 26'd6);

        // Reset in the middle of an advance.
        tick();
        req = 4'b0001;
        wait_adv();
        clear_logs();
        rst = 1'b1;
        #1;
        check("f_gnt", 26'(gnt), 26'd0);
        check("f_load", 26'(lfsr_load), 26'd0);
        check("f_rst_n", 26'(lfsr_rst_n), 26'd0);
`ifdef LFSR_RR_STAT_EN
        check("f_gnt_cnt", 26'(gnt_cnt), 26'd0);
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("f_q_seed", lfsr_q, 26'h2AAAAAA);
        wait_grants(1, 20);
        check("f_word", g_dat[0], 26'h2AAAAAD);
        tick();
`ifdef LFSR_RR_STAT_EN
        check("f_gnt_cnt_one", 26'(gnt_cnt), 26'd1);
`endif

        // Randomised traffic with reseeds, dropped requests and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 700 == 0) begin
                do_reset(1 + int'($urandom % 3));
            end else begin
                for (int b = 0; b < NREQ; b++)
                    if (!req[b] && ($urandom % 8 == 0)) req[b] = 1'b1;
                if ($urandom % 60 == 0) req[$urandom % NREQ] = 1'b0;
                if ($urandom % 40 == 0) begin
                    seed_wr = 1'b1;
                    seed    = ($urandom % 4 == 0) ? 26'd0 : 26'($urandom);
                end
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
